uart_apb_sequencer: RTL and testbench

//  APB3 master that owns one CoreUARTapb slave: after reset it programs baud/format

---
 rtl/uart_apb_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// ---------------------------------------------------------------------------
// uart_apb_sequencer
//
// APB3 master that owns a single CoreUARTapb slave. After reset it writes the
// baud/format registers (CTRL1, CTRL2, CTRL3). It then polls STATUS in a loop:
//   - a received byte is drained into a 1-deep rx buffer (rx_data/rx_valid);
//   - otherwise a pending TX byte from one of NREQ requesters is written,
//     with requesters chosen round-robin.
// RX is chosen over TX so that the UART receive holding register never
// overflows while TX traffic is waiting.
//
// Handshakes:
//   rx_valid/rx_ready : a byte moves when rx_valid & rx_ready are both high
//                       on a rising edge. rx_valid stays high and rx_data
//                       stays stable until that edge.
//   tx_req/tx_ack     : tx_req[i] is a level, held with stable tx_data until
//                       tx_ack[i] pulses for one cycle. That pulse is in the
//                       cycle in which the APB write of the byte completes.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA         APB master request (all registered)
//   PRDATA/PREADY/PSLVERR APB slave response
//   cfg_start             re-run the config writes (taken in POLL_S only)
//   cfg_done              high after the config writes complete
//   tx_req/tx_data/tx_ack TX requesters
//   rx_data/rx_valid/
//   rx_ready              received byte buffer
//   err_flags/err_clr     sticky {PSLVERR, FRAMING, OVERFLOW, PARITY}
//   dbg_state             current FSM state
// ---------------------------------------------------------------------------
module uart_apb_sequencer #(
    parameter int          NREQ       = 2,
    parameter logic [12:0] BAUD_VAL   = 13'd1,
    parameter logic [2:0]  BAUD_FRAC  = 3'd0,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    output logic [4:0]        PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic              cfg_start,
    output logic              cfg_done,
    input  logic [NREQ-1:0]   tx_req,
    input  logic [8*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]   tx_ack,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [3:0]        err_flags,
    input  logic              err_clr,
    output logic [3:0]        dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [4:0] A_TX     = 5'h00;
    localparam logic [4:0] A_RX     = 5'h04;
    localparam logic [4:0] A_CTRL1  = 5'h08;
    localparam logic [4:0] A_CTRL2  = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
    localparam logic [4:0] A_CTRL3  = 5'h14;

    localparam logic [7:0] CTRL1_VAL = BAUD_VAL[7:0];
    localparam logic [7:0] CTRL2_VAL = {BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
    localparam logic [7:0] CTRL3_VAL = {5'b0, BAUD_FRAC};

    // x_S = SETUP phase on the bus, x_A = ACCESS phase on the bus.
    typedef enum logic [3:0] {
        C1_S   = 4'd0,
        C1_A   = 4'd1,
        C2_S   = 4'd2,
        C2_A   = 4'd3,
        C3_S   = 4'd4,
        C3_A   = 4'd5,
        POLL_S = 4'd6,
        POLL_A = 4'd7,
        RX_S   = 4'd8,
        RX_A   = 4'd9,
        TX_S   = 4'd10,
        TX_A   = 4'd11
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_grant;

    logic            w_done;
    logic            w_found;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_grant;
    logic [PW-1:0]   w_ptr_next;
    logic [7:0]      w_tx_byte;
    logic [3:0]      w_err_set;

    assign dbg_state = r_state;
    assign w_done    = PENABLE & PREADY;

    // First requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && tx_req[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_tx_byte  = tx_data[{w_grant, 3'b000} +: 8];
    assign w_ptr_next = PW'((int'(r_grant) + 1) % NREQ);

    // The ack must land in the completion cycle itself, so it decodes PREADY
    // directly rather than waiting for a register.
    always_comb begin
        tx_ack = '0;
        if (r_state == TX_A && PREADY) begin
            tx_ack = NREQ'(1) << r_grant;
        end
    end

    // Error bits collected on this edge; STATUS bits only count on a poll.
    always_comb begin
        w_err_set = 4'b0;
        if (w_done) begin
            w_err_set[3] = PSLVERR;
            if (r_state == POLL_A) begin
                w_err_set[2:0] = PRDATA[4:2];
            end
        end
    end

    // Put a new SETUP phase on the bus.
    task automatic start_setup(input state_t s, input logic [4:0] a,
                               input logic w, input logic [7:0] d);
        r_state <= s;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PADDR   <= a;
        PWRITE  <= w;
        PWDATA  <= d;
    endtask

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= C1_S;
            r_ptr     <= '0;
            r_grant   <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= 5'h00;
            PWRITE    <= 1'b0;
            PWDATA    <= 8'h00;
            cfg_done  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            err_flags <= 4'b0;
        end else begin
            // A clear and a set on the same edge: the set survives.
            err_flags <= (err_clr ? 4'b0 : err_flags) | w_err_set;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (r_state)
                // C1_S is also entered with the bus idle (after reset or a
                // cfg_start); in that case this cycle just raises SETUP.
                C1_S: begin
                    if (!PSEL) begin
                        start_setup(C1_S, A_CTRL1, 1'b1, CTRL1_VAL);
                    end else begin
                        PENABLE <= 1'b1;
                        r_state <= C1_A;
                    end
                end
                C1_A: if (w_done) start_setup(C2_S, A_CTRL2, 1'b1, CTRL2_VAL);
                C2_S: begin
                    PENABLE <= 1'b1;
                    r_state <= C2_A;
                end
                C2_A: if (w_done) start_setup(C3_S, A_CTRL3, 1'b1, CTRL3_VAL);
                C3_S: begin
                    PENABLE <= 1'b1;
                    r_state <= C3_A;
                end
                C3_A: begin
                    if (w_done) begin
                        cfg_done <= 1'b1;
                        start_setup(POLL_S, A_STATUS, 1'b0, 8'h00);
                    end
                end
                POLL_S: begin
                    if (cfg_start) begin
                        cfg_done <= 1'b0;
                        r_state  <= C1_S;
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        PADDR    <= 5'h00;
                        PWRITE   <= 1'b0;
                        PWDATA   <= 8'h00;
                    end else begin
                        PENABLE <= 1'b1;
                        r_state <= POLL_A;
                    end
                end
                POLL_A: begin
                    if (w_done) begin
                        // A read is only issued into an empty buffer, so the
                        // RX load can never collide with a consumer handshake.
                        if (PRDATA[1] && !rx_valid) begin
                            start_setup(RX_S, A_RX, 1'b0, 8'h00);
                        end else if (PRDATA[0] && w_found) begin
                            r_grant <= w_grant;
                            start_setup(TX_S, A_TX, 1'b1, w_tx_byte);
                        end else begin
                            start_setup(POLL_S, A_STATUS, 1'b0, 8'h00);
                        end
                    end
                end
                RX_S: begin
                    PENABLE <= 1'b1;
                    r_state <= RX_A;
                end
                RX_A: begin
                    if (w_done) begin
                        rx_data  <= PRDATA;
                        rx_valid <= 1'b1;
                        start_setup(POLL_S, A_STATUS, 1'b0, 8'h00);
                    end
                end
                TX_S: begin
                    PENABLE <= 1'b1;
                    r_state <= TX_A;
                end
                TX_A: begin
                    if (w_done) begin
                        r_ptr <= w_ptr_next;
                        start_setup(POLL_S, A_STATUS, 1'b0, 8'h00);
                    end
                end
                default: begin
                    r_state <= C1_S;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_apb_sequencer
//
// Lockstep bench: each table record describes one APB transfer the sequencer
// is expected to issue, the slave response to give it, the requester /
// consumer inputs to hold during it, and the status outputs expected while
// its SETUP phase is on the bus. Hand-written sequences cover cfg_start and a
// reset in the middle of a TX access.
// ---------------------------------------------------------------------------
module tb_uart_apb_sequencer;

    localparam int NREQ = 2;

    logic              PCLK;
    logic              PRESET;
    logic [4:0]        PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [7:0]        PWDATA;
    logic [7:0]        PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              cfg_start;
    logic              cfg_done;
    logic [NREQ-1:0]   tx_req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   tx_ack;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [3:0]        err_flags;
    logic              err_clr;
    logic [3:0]        dbg_state;

    uart_apb_sequencer #(
        .NREQ       (NREQ),
        .BAUD_VAL   (13'h155),
        .BAUD_FRAC  (3'd3),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b1),
        .ODD_N_EVEN (1'b0)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .cfg_start (cfg_start),
        .cfg_done  (cfg_done),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_ack    (tx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_flags (err_flags),
        .err_clr   (err_clr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];   // bytes expected to appear on rx_data, in order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] addr;   // expected PADDR
        logic       wr;     // expected PWRITE
        logic [7:0] wdata;  // expected PWDATA
        logic [7:0] rdata;  // PRDATA returned at completion
        int         waits;  // PREADY-low cycles in ACCESS
        logic       slverr; // PSLVERR at completion
        logic [1:0] req;    // tx_req held during transfer
        logic       rdy;    // rx_ready held during transfer
        logic       clr;    // err_clr held during transfer
        logic [1:0] ack;    // expected tx_ack at completion
        logic       cfg;    // expected cfg_done during SETUP
        logic       rxv;    // expected rx_valid during SETUP
        logic [3:0] err;    // expected err_flags during SETUP
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic [4:0] addr, logic wr, logic [7:0] wdata,
                                logic [7:0] rdata, int waits, logic slverr,
                                logic [1:0] req, logic rdy, logic clr, logic [1:0] ack,
                                logic cfg, logic rxv, logic [3:0] err);
        vec_t v;
        v.addr = addr; v.wr = wr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.slverr = slverr; v.req = req; v.rdy = rdy;
        v.clr = clr; v.ack = ack; v.cfg = cfg; v.rxv = rxv; v.err = err;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge with the SETUP phase of the transfer
    // on the bus; returns just after the edge that completed it.
    task automatic apply_vec(input vec_t t);
        tx_req   = t.req;
        rx_ready = t.rdy;
        err_clr  = t.clr;
        PREADY   = 1'b0;
        PRDATA   = 8'h00;
        PSLVERR  = 1'b0;
        if (t.addr == 5'h04 && !t.wr) exp_q.push_back(t.rdata);
        @(negedge PCLK);
        check("setup_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
              {1'b1, 1'b0, t.wr, t.addr, t.wdata});
        check("cfg_done", cfg_done, t.cfg);
        check("rx_valid", rx_valid, t.rxv);
        if (t.rxv) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_data: got 0x%0h expected none queued", rx_data);
            end else begin
                check("rx_data", rx_data, exp_q[0]);
                if (t.rdy) void'(exp_q.pop_front());
            end
        end
        check("err_flags", err_flags, t.err);
        check("ack_setup", tx_ack, 0);
        @(posedge PCLK); #1;
        for (int w = 0; w <= t.waits; w++) begin
            PREADY = (w == t.waits);
            if (w == t.waits) begin
                PRDATA  = t.rdata;
                PSLVERR = t.slverr;
            end
            @(negedge PCLK);
            check("access_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                  {1'b1, 1'b1, t.wr, t.addr, t.wdata});
            check("tx_ack", tx_ack, (w == t.waits) ? t.ack : 2'b00);
            @(posedge PCLK); #1;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
    endtask

    vec_t tv;

    // ---------------- test ----------------
    initial begin
        PRESET    = 1'b1;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        cfg_start = 1'b0;
        tx_req    = '0;
        tx_data   = 16'hB2A1;
        rx_ready  = 1'b0;
        err_clr   = 1'b0;

        //            addr  wr wdata  rdata w sl req  rdy clr ack  cfg rxv err
        vecs[0]  = mk(5'h08,1,8'h55,8'h00,0,0,2'b00,0,0,2'b00,0,0,4'h0);
        vecs[1]  = mk(5'h0C,1,8'h0B,8'h00,0,0,2'b00,0,0,2'b00,0,0,4'h0);
        vecs[2]  = mk(5'h14,1,8'h03,8'h00,0,0,2'b00,0,0,2'b00,0,0,4'h0);
        vecs[3]  = mk(5'h10,0,8'h00,8'h00,0,0,2'b00,0,0,2'b00,1,0,4'h0);
        vecs[4]  = mk(5'h10,0,8'h00,8'h01,0,0,2'b11,0,0,2'b00,1,0,4'h0);
        vecs[5]  = mk(5'h00,1,8'hA1,8'h00,0,0,2'b11,0,0,2'b01,1,0,4'h0);
        vecs[6]  = mk(5'h10,0,8'h00,8'h01,0,0,2'b10,0,0,2'b00,1,0,4'h0);
        vecs[7]  = mk(5'h00,1,8'hB2,8'h00,0,0,2'b10,0,0,2'b10,1,0,4'h0);
        vecs[8]  = mk(5'h10,0,8'h00,8'h01,0,0,2'b11,0,0,2'b00,1,0,4'h0);
        vecs[9]  = mk(5'h00,1,8'hA1,8'h00,3,0,2'b11,0,0,2'b01,1,0,4'h0);
        vecs[10] = mk(5'h10,0,8'h00,8'h03,0,0,2'b10,0,0,2'b00,1,0,4'h0);
        vecs[11] = mk(5'h04,0,8'h00,8'h5C,0,0,2'b10,0,0,2'b00,1,0,4'h0);
        vecs[12] = mk(5'h10,0,8'h00,8'h03,0,0,2'b10,0,0,2'b00,1,1,4'h0);
        vecs[13] = mk(5'h00,1,8'hB2,8'h00,0,0,2'b10,0,0,2'b10,1,1,4'h0);
        vecs[14] = mk(5'h10,0,8'h00,8'h02,0,0,2'b00,0,0,2'b00,1,1,4'h0);
        vecs[15] = mk(5'h10,0,8'h00,8'h02,0,0,2'b00,1,0,2'b00,1,1,4'h0);
        vecs[16] = mk(5'h04,0,8'h00,8'h3E,0,0,2'b00,0,0,2'b00,1,0,4'h0);
        vecs[17] = mk(5'h10,0,8'h00,8'h00,0,0,2'b00,0,0,2'b00,1,1,4'h0);
        vecs[18] = mk(5'h10,0,8'h00,8'h14,0,0,2'b00,0,0,2'b00,1,1,4'h0);
        vecs[19] = mk(5'h10,0,8'h00,8'h00,0,0,2'b00,0,1,2'b00,1,1,4'h5);
        vecs[20] = mk(5'h10,0,8'h00,8'h14,0,0,2'b00,0,1,2'b00,1,1,4'h0);
        vecs[21] = mk(5'h10,0,8'h00,8'h00,0,1,2'b00,0,0,2'b00,1,1,4'h5);
        vecs[22] = mk(5'h10,0,8'h00,8'h00,0,0,2'b00,0,1,2'b00,1,1,4'hD);
        vecs[23] = mk(5'h10,0,8'h00,8'h00,0,0,2'b00,1,0,2'b00,1,1,4'h0);

        // Reset state.
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 16'h0000);
        check("rst_outs", {cfg_done, rx_valid, err_flags, tx_ack, rx_data}, 0);
        check("rst_state", dbg_state, 4'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Config writes, polling, round-robin TX, RX priority, wait states,
        // rx buffer back-pressure and drain, sticky error flags.
        for (int i = 0; i < 24; i++) begin
            apply_vec(vecs[i]);
        end
        rx_ready = 1'b0;
        err_clr  = 1'b0;

        // cfg_start in POLL_S: bus goes idle one cycle, config re-runs.
        cfg_start = 1'b1;
        @(posedge PCLK); #1;
        cfg_start = 1'b0;
        @(negedge PCLK);
        check("cfgs_idle", {PSEL, PENABLE}, 2'b00);
        check("cfgs_done_low", cfg_done, 1'b0);
        @(posedge PCLK); #1;
        for (int i = 0; i < 4; i++) begin
            apply_vec(vecs[i]);
        end

        // Reset during TX_A: bus drops at once, no ack, config restarts.
        tv = vecs[4];
        tv.req = 2'b01;
        apply_vec(tv);
        tx_req = 2'b01;
        @(negedge PCLK);
        check("rtx_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 5'h00, 8'hA1});
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("rtx_access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 5'h00, 8'hA1});
        PREADY = 1'b1;
        PRESET = 1'b1;
        #1;
        check("rtx_bus_drop", {PSEL, PENABLE}, 2'b00);
        check("rtx_no_ack", tx_ack, 2'b00);
        check("rtx_state", dbg_state, 4'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        PREADY = 1'b0;
        @(posedge PCLK); #1;
        apply_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
